// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry accumulator: command opcodes, FSM states
// and the adder width.
package rca_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_ADD   = 2'b10,
        OP_ADDC  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/rca_adder.sv
// Purely combinational ripple-carry adder: res = x + y + ci, with co as the carry
// out of the MSB. The carry ripples through one full adder per bit.
module rca_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic         co,
    output logic [W-1:0] res
);

    logic [W:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign res[gi]  = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi+1]  = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co = c[W];

endmodule

// File: rtl/rca_accumulator.sv
// Accumulator stage around the ripple-carry adder: operands are held stable for
// SETTLE_CYC cycles so the carry chain can settle before res/co are captured.
module rca_accumulator #(
    parameter int WIDTH      = rca_pkg::WIDTH,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             out_valid,
    output logic             busy
);

    import rca_pkg::*;

    localparam int SC_W = 4;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYC - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  acc_reg;
    logic [WIDTH-1:0]  y_reg;
    logic              ci_reg;
    logic              carry_reg;
    logic [CNT_W-1:0]  ovf_cnt_reg;
    logic [SC_W-1:0]   cnt_reg;

    logic              accept;
    logic              settle_last;
    logic              add_co;
    logic [WIDTH-1:0]  add_res;

    // x comes straight from the accumulator; y and ci are latched at accept so all
    // three stay constant while the chain settles.
    rca_adder #(
        .W (WIDTH)
    ) u_adder (
        .x   (acc_reg),
        .y   (y_reg),
        .ci  (ci_reg),
        .co  (add_co),
        .res (add_res)
    );

    assign accept      = in_valid && (state_reg == IDLE);
    assign settle_last = (state_reg == SETTLE) && (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (in_op == OP_ADD || in_op == OP_ADDC) begin
                        state_next = SETTLE;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            y_reg       <= '0;
            ci_reg      <= 1'b0;
            carry_reg   <= 1'b0;
            ovf_cnt_reg <= '0;
            cnt_reg     <= '0;
        end else if (accept) begin
            case (in_op)
                OP_CLEAR: begin
                    acc_reg     <= '0;
                    carry_reg   <= 1'b0;
                    ovf_cnt_reg <= '0;
                end
                OP_LOAD: begin
                    acc_reg <= in_data;
                end
                OP_ADD: begin
                    y_reg   <= in_data;
                    ci_reg  <= 1'b0;
                    cnt_reg <= SETTLE_LOAD;
                end
                default: begin
                    y_reg   <= in_data;
                    ci_reg  <= carry_reg;
                    cnt_reg <= SETTLE_LOAD;
                end
            endcase
        end else if (settle_last) begin
            acc_reg   <= add_res;
            carry_reg <= add_co;
            if (add_co && (ovf_cnt_reg != '1)) begin
                ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
            end
        end else if (state_reg == SETTLE) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign acc       = acc_reg;
    assign carry     = carry_reg;
    assign ovf_cnt   = ovf_cnt_reg;

endmodule

// File: doc/rca_accumulator.md
Name: rca_accumulator

Overview:
- Sequential accumulator stage wrapped around the team's existing 32-bit ripple-carry adder (ports x, y, ci, co, res).
- Drives the adder's x input from its own accumulator register, and its y and ci inputs from latched operands.
- Waits a programmable number of cycles for the ripple chain to settle, then writes res and co back.
- Supports multi-word (chained-carry) addition through an add-with-carry op.

Parameters:
- WIDTH, 32, datapath width. Fixed to the adder width; other values are unsupported.
- SETTLE_CYC, 2, clock cycles the adder inputs are held stable before result capture. Legal range 1..15.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command valid
- in_ready  out  1  block can accept a command
- in_op  in  2  00 CLEAR, 01 LOAD, 10 ADD, 11 ADDC
- in_data  in  WIDTH  operand
- acc  out  WIDTH  accumulator value
- carry  out  1  carry flag from the last ADD/ADDC
- ovf_cnt  out  CNT_W  count of ADD/ADDC results with co=1, saturating
- out_valid  out  1  one-cycle pulse: command completed and acc/carry are updated
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): acc=0, carry=0, ovf_cnt=0, out_valid=0, state=IDLE. Reset mid-operation aborts the command; no out_valid is produced.
- States: IDLE, SETTLE, DONE.
  - in_ready = (state==IDLE).
  - Accept = in_valid && in_ready at a rising edge. in_data and in_op are ignored at all other times.
- CLEAR accepted:
  - acc<=0, carry<=0, ovf_cnt<=0.
  - Next state DONE.
- LOAD accepted:
  - acc<=in_data. carry and ovf_cnt are unchanged, so carry chains across words.
  - Next state DONE.
- ADD / ADDC accepted:
  - y_reg<=in_data.
  - ci_reg<=0 for ADD; ci_reg<=carry for ADDC.
  - cnt<=SETTLE_CYC-1; next state SETTLE.
- Adder connection: x=acc, y=y_reg, ci=ci_reg. All three hold constant throughout SETTLE.
- SETTLE:
  - When cnt!=0: cnt decrements each edge.
  - When cnt==0 at an edge: acc<=res, carry<=co, ovf_cnt<=ovf_cnt+co, with the counter saturating at all-ones. Next state DONE.
- DONE:
  - out_valid=1 for exactly this cycle; in_ready=0.
  - Next state IDLE.
- Latency, counted from the accept edge E0:
  - CLEAR/LOAD: outputs updated at E0; out_valid high in the following cycle.
  - ADD/ADDC: outputs updated at edge E0+SETTLE_CYC; out_valid high in the following cycle.
  - In both cases in_ready returns in the cycle after DONE.
- Arithmetic is modulo 2^WIDTH; co is the carry-out of the MSB. No signed overflow detection.
- in_data changes during SETTLE/DONE have no effect on the result.
- out_valid is registered (state decode only), never combinational from inputs.

Decomposition:
- Shared package rca_pkg holds:
  - op encodings (OP_CLEAR, OP_LOAD, OP_ADD, OP_ADDC)
  - state enum (IDLE, SETTLE, DONE)
  - WIDTH=32 constant
- One sub-module: the existing 32-bit ripple-carry adder, instantiated unchanged.
- The FSM, counter and registers stay in rca_accumulator.

Test Plan (SETTLE_CYC=2 unless stated):
- Reset: rst_n=0 -> acc=0, carry=0, ovf_cnt=0, out_valid=0. After release, in_ready=1 and busy=0.
- Simple add: LOAD 0x00000011, then ADD 0x00000011 -> acc=0x00000022, carry=0. For the ADD: out_valid pulses once, 3 cycles after the accept edge; in_ready low for 3 cycles.
- Wrap and chain: LOAD 0xFFFFFFFF, ADD 0x00000001 -> acc=0x00000000, carry=1, ovf_cnt=1. Then ADDC 0x00000000 -> acc=0x00000001, carry=0, ovf_cnt=1.
- 64-bit chain: LOAD 0x80000000, ADD 0x80000000 -> acc=0, carry=1. Then LOAD 0x10001000 (carry stays 1), ADDC 0x10001000 -> acc=0x20002001, carry=0.
- Busy rejection: hold in_valid=1 and change in_data to 0xDEADBEEF during SETTLE -> no accept, in_ready=0, result unaffected. A queued command is accepted only after DONE.
- Reset mid-SETTLE, and saturation with CNT_W=2:
  - rst_n low during SETTLE -> acc=0 immediately, no out_valid pulse.
  - Four successive LOAD 0xFFFFFFFF / ADD 0x00000001 pairs -> ovf_cnt stays 3.
